// File: rtl/decoder_dbg_pkg.sv
// ---------------------------------------------------------------------------
// decoder_dbg_pkg
// Shared types for the decoder debug/deadlock reporting path.
//   state_t : reporter FSM states
//   rpt_t   : one report record (which AXIS channels blocked, qualifying count)
//   NUM_AXIS: number of AXIS block bits produced by the deadlock monitor
// ---------------------------------------------------------------------------
package decoder_dbg_pkg;

    localparam int NUM_AXIS  = 4;
    // Widest hang counter a report record is expected to carry.
    localparam int RPT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [NUM_AXIS-1:0]  chan;
        logic [RPT_CNT_W-1:0] cycles;
    } rpt_t;

endpackage : decoder_dbg_pkg

// File: rtl/decoder_hls_deadlock_reporter_if.sv
// ---------------------------------------------------------------------------
// decoder_hls_deadlock_reporter_if
// Valid/ready channel carrying one deadlock report record to the logger.
//   rpt_valid  : record valid (producer)
//   rpt_ready  : logger accepts the record (consumer)
//   rpt_chan   : AXIS channels that blocked during the qualifying window
//   rpt_cycles : block count at qualification
// Modports: master = reporter side, slave = logger side.
// ---------------------------------------------------------------------------
interface decoder_hls_deadlock_reporter_if
    import decoder_dbg_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int N_AXIS   = NUM_AXIS
);
    logic              rpt_valid;
    logic              rpt_ready;
    logic [N_AXIS-1:0] rpt_chan;
    logic [CNT_W-1:0]  rpt_cycles;

    modport master (
        output rpt_valid,
        output rpt_chan,
        output rpt_cycles,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_chan,
        input  rpt_cycles,
        output rpt_ready
    );

endinterface : decoder_hls_deadlock_reporter_if

// File: rtl/decoder_hls_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// decoder_hls_deadlock_reporter
// Turns the decoder deadlock monitor's registered block flag into a qualified
// deadlock: the flag must stay high THRESHOLD consecutive cycles. On
// qualification one report record (blocked AXIS channels + count) is offered
// to the logger; while the deadlock persists a level flag is held and the
// hang cycles are counted (saturating).
// Ports:
//   clock           : clock
//   reset_n         : synchronous reset, active low
//   block           : registered block flag from the deadlock monitor
//   axis_block_sigs : raw per-channel block bits, OR-ed over the window
//   deadlock_active : qualified deadlock in progress (registered)
//   hang_cycles     : current consecutive-block count (registered, saturating)
//   rpt             : report record channel (master side)
// ---------------------------------------------------------------------------
module decoder_hls_deadlock_reporter
    import decoder_dbg_pkg::*;
#(
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 16,
    parameter int N_AXIS    = NUM_AXIS
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            block,
    input  logic [N_AXIS-1:0]               axis_block_sigs,
    output logic                            deadlock_active,
    output logic [CNT_W-1:0]                hang_cycles,
    decoder_hls_deadlock_reporter_if.master rpt
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_AXIS-1:0]   r_chan_acc;
    logic                r_rpt_valid;
    logic [N_AXIS-1:0]   r_rpt_chan;
    logic [CNT_W-1:0]    r_rpt_cycles;
    logic                r_deadlock_active;
    // Set once block has been seen low while the record is still pending, so
    // the eventual handshake returns to IDLE even if block rose again.
    logic                r_low_seen;

    state_t              w_state_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [N_AXIS-1:0]   w_chan_acc_next;
    logic                w_rpt_valid_next;
    logic [N_AXIS-1:0]   w_rpt_chan_next;
    logic [CNT_W-1:0]    w_rpt_cycles_next;
    logic                w_deadlock_active_next;
    logic                w_low_seen_next;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_handshake;

    assign w_cnt_inc   = sat_inc(r_cnt);
    assign w_handshake = r_rpt_valid & rpt.rpt_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_cnt             <= '0;
            r_chan_acc        <= '0;
            r_rpt_valid       <= 1'b0;
            r_rpt_chan        <= '0;
            r_rpt_cycles      <= '0;
            r_deadlock_active <= 1'b0;
            r_low_seen        <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_cnt             <= w_cnt_next;
            r_chan_acc        <= w_chan_acc_next;
            r_rpt_valid       <= w_rpt_valid_next;
            r_rpt_chan        <= w_rpt_chan_next;
            r_rpt_cycles      <= w_rpt_cycles_next;
            r_deadlock_active <= w_deadlock_active_next;
            r_low_seen        <= w_low_seen_next;
        end
    end

    always_comb begin
        w_state_next           = r_state;
        w_cnt_next             = r_cnt;
        w_chan_acc_next        = r_chan_acc;
        w_rpt_valid_next       = r_rpt_valid;
        w_rpt_chan_next        = r_rpt_chan;
        w_rpt_cycles_next      = r_rpt_cycles;
        w_deadlock_active_next = r_deadlock_active;
        w_low_seen_next        = r_low_seen;

        unique case (r_state)
            ST_IDLE: begin
                w_deadlock_active_next = 1'b0;
                w_low_seen_next        = 1'b0;
                if (block) begin
                    w_cnt_next      = CNT_W'(1);
                    w_chan_acc_next = axis_block_sigs;
                    w_state_next    = ST_COUNT;
                end else begin
                    w_cnt_next = '0;
                end
            end

            ST_COUNT: begin
                if (!block) begin
                    w_cnt_next      = '0;
                    w_chan_acc_next = '0;
                    w_state_next    = ST_IDLE;
                end else begin
                    w_cnt_next      = w_cnt_inc;
                    w_chan_acc_next = r_chan_acc | axis_block_sigs;
                    if (w_cnt_inc == THRESH_C) begin
                        // The record includes this cycle's channel bits.
                        w_rpt_chan_next        = r_chan_acc | axis_block_sigs;
                        w_rpt_cycles_next      = THRESH_C;
                        w_rpt_valid_next       = 1'b1;
                        w_deadlock_active_next = 1'b1;
                        w_state_next           = ST_REPORT;
                    end
                end
            end

            ST_REPORT: begin
                // The record is never retracted; only the level flag and the
                // counter follow block while waiting for the logger.
                if (block) begin
                    w_cnt_next             = w_cnt_inc;
                    w_deadlock_active_next = ~r_low_seen;
                end else begin
                    w_cnt_next             = '0;
                    w_deadlock_active_next = 1'b0;
                    w_low_seen_next        = 1'b1;
                end
                if (w_handshake) begin
                    w_rpt_valid_next = 1'b0;
                    if (block && !r_low_seen) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_cnt_next             = '0;
                        w_chan_acc_next        = '0;
                        w_deadlock_active_next = 1'b0;
                        w_low_seen_next        = 1'b0;
                        w_state_next           = ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                if (block) begin
                    w_cnt_next             = w_cnt_inc;
                    w_deadlock_active_next = 1'b1;
                end else begin
                    w_cnt_next             = '0;
                    w_chan_acc_next        = '0;
                    w_deadlock_active_next = 1'b0;
                    w_state_next           = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign deadlock_active = r_deadlock_active;
    assign hang_cycles     = r_cnt;
    assign rpt.rpt_valid   = r_rpt_valid;
    assign rpt.rpt_chan    = r_rpt_chan;
    assign rpt.rpt_cycles  = r_rpt_cycles;

endmodule : decoder_hls_deadlock_reporter

// File: tb/tb_decoder_hls_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// tb_decoder_hls_deadlock_reporter
// Two reporters with THRESHOLD=8: one with a 16-bit counter (main scenarios)
// and one with a 4-bit counter (saturation). Expected records are queued when
// the qualifying stimulus is driven and popped when the logger side accepts.
// ---------------------------------------------------------------------------
module tb_decoder_hls_deadlock_reporter;
    import decoder_dbg_pkg::*;

    localparam int TH = 8;

    logic        clock;
    logic        reset_n;
    logic        block_a, block_b;
    logic [3:0]  axis_a, axis_b;
    logic        da_a, da_b;
    logic [15:0] hang_a;
    logic [3:0]  hang_b;

    int n_checks = 0;
    int n_errors = 0;
    int rec_a    = 0;
    int rec_b    = 0;

    rpt_t q_a[$];
    rpt_t q_b[$];

    decoder_hls_deadlock_reporter_if #(.CNT_W(16)) if_a ();
    decoder_hls_deadlock_reporter_if #(.CNT_W(4))  if_b ();

    decoder_hls_deadlock_reporter #(.THRESHOLD(TH), .CNT_W(16)) dut_a (
        .clock           (clock),
        .reset_n         (reset_n),
        .block           (block_a),
        .axis_block_sigs (axis_a),
        .deadlock_active (da_a),
        .hang_cycles     (hang_a),
        .rpt             (if_a)
    );

    decoder_hls_deadlock_reporter #(.THRESHOLD(TH), .CNT_W(4)) dut_b (
        .clock           (clock),
        .reset_n         (reset_n),
        .block           (block_b),
        .axis_block_sigs (axis_b),
        .deadlock_active (da_b),
        .hang_cycles     (hang_b),
        .rpt             (if_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after posedge, so at negedge they are stable
    // and valid&ready here means a handshake at the coming edge.
    always @(negedge clock) begin
        if (reset_n && if_a.rpt_valid && if_a.rpt_ready) begin
            rpt_t e;
            rec_a++;
            n_checks++;
            if (q_a.size() == 0) begin
                n_errors++;
                $display("FAIL rec_a: unexpected record chan=%b cycles=%0d", if_a.rpt_chan, if_a.rpt_cycles);
            end else begin
                e = q_a.pop_front();
                if (if_a.rpt_chan !== e.chan || if_a.rpt_cycles !== e.cycles) begin
                    n_errors++;
                    $display("FAIL rec_a: got chan=%b cycles=%0d expected chan=%b cycles=%0d",
                             if_a.rpt_chan, if_a.rpt_cycles, e.chan, e.cycles);
                end else begin
                    $display("rec_a accepted chan=%b cycles=%0d", if_a.rpt_chan, if_a.rpt_cycles);
                end
            end
        end
        if (reset_n && if_b.rpt_valid && if_b.rpt_ready) begin
            rpt_t e;
            rec_b++;
            n_checks++;
            if (q_b.size() == 0) begin
                n_errors++;
                $display("FAIL rec_b: unexpected record chan=%b cycles=%0d", if_b.rpt_chan, if_b.rpt_cycles);
            end else begin
                e = q_b.pop_front();
                if (if_b.rpt_chan !== e.chan || if_b.rpt_cycles !== 4'(e.cycles)) begin
                    n_errors++;
                    $display("FAIL rec_b: got chan=%b cycles=%0d expected chan=%b cycles=%0d",
                             if_b.rpt_chan, if_b.rpt_cycles, e.chan, 4'(e.cycles));
                end else begin
                    $display("rec_b accepted chan=%b cycles=%0d", if_b.rpt_chan, if_b.rpt_cycles);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        block_a = 1'b0; block_b = 1'b0;
        axis_a  = 4'b0; axis_b  = 4'b0;
        if_a.rpt_ready = 1'b0;
        if_b.rpt_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (da_a !== 1'b0 || hang_a !== 16'd0 || if_a.rpt_valid !== 1'b0 ||
            if_a.rpt_chan !== 4'd0 || if_a.rpt_cycles !== 16'd0 ||
            da_b !== 1'b0 || hang_b !== 4'd0 || if_b.rpt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: got da=%b hang=%0d valid=%b chan=%b cyc=%0d required all 0",
                     da_a, hang_a, if_a.rpt_valid, if_a.rpt_chan, if_a.rpt_cycles);
        end
        $display("reset checked");
        reset_n = 1'b1;
        tick();
    endtask

    // T1: qualification latency, count and channel attribution.
    task automatic test_threshold();
        axis_a  = 4'b0010;
        block_a = 1'b1;
        q_a.push_back('{chan: 4'b0010, cycles: 16'(TH)});
        for (int i = 1; i <= TH; i++) begin
            logic exp_v;
            exp_v = (i == TH);
            tick();
            n_checks++;
            if (if_a.rpt_valid !== exp_v || hang_a !== 16'(i) || da_a !== exp_v) begin
                n_errors++;
                $display("FAIL threshold edge %0d: got valid=%b hang=%0d da=%b required valid=%b hang=%0d da=%b",
                         i, if_a.rpt_valid, hang_a, da_a, exp_v, i, exp_v);
            end
        end
        n_checks++;
        if (if_a.rpt_cycles !== 16'(TH) || if_a.rpt_chan !== 4'b0010) begin
            n_errors++;
            $display("FAIL threshold payload: got chan=%b cycles=%0d required chan=0010 cycles=%0d",
                     if_a.rpt_chan, if_a.rpt_cycles, TH);
        end
        if_a.rpt_ready = 1'b1;
        tick();
        if_a.rpt_ready = 1'b0;
        n_checks++;
        if (if_a.rpt_valid !== 1'b0 || da_a !== 1'b1 || hang_a !== 16'(TH + 1)) begin
            n_errors++;
            $display("FAIL threshold hold: got valid=%b da=%b hang=%0d required valid=0 da=1 hang=%0d",
                     if_a.rpt_valid, da_a, hang_a, TH + 1);
        end
        block_a = 1'b0;
        tick();
        n_checks++;
        if (da_a !== 1'b0 || hang_a !== 16'd0) begin
            n_errors++;
            $display("FAIL threshold release: got da=%b hang=%0d required 0 0", da_a, hang_a);
        end
        $display("threshold scenario done");
        tick();
    endtask

    // T2: one cycle short of qualifying gives no report.
    task automatic test_short_block();
        axis_a  = 4'b0100;
        block_a = 1'b1;
        for (int i = 1; i < TH; i++) begin
            tick();
            n_checks++;
            if (if_a.rpt_valid !== 1'b0 || da_a !== 1'b0) begin
                n_errors++;
                $display("FAIL short edge %0d: got valid=%b da=%b required 0 0", i, if_a.rpt_valid, da_a);
            end
        end
        block_a = 1'b0;
        tick();
        n_checks++;
        if (hang_a !== 16'd0 || if_a.rpt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL short release: got hang=%0d valid=%b required 0 0", hang_a, if_a.rpt_valid);
        end
        // A fresh rise counts from 1, which only happens from IDLE.
        block_a = 1'b1;
        tick();
        n_checks++;
        if (hang_a !== 16'd1) begin
            n_errors++;
            $display("FAIL short idle: got hang=%0d required 1", hang_a);
        end
        block_a = 1'b0;
        tick();
        $display("short block scenario done");
    endtask

    // T3: backpressure keeps the record stable; acceptance moves to HOLD.
    task automatic test_backpressure();
        int bad = 0;
        axis_a  = 4'b0101;
        block_a = 1'b1;
        q_a.push_back('{chan: 4'b0101, cycles: 16'(TH)});
        for (int i = 1; i <= TH; i++) tick();
        n_checks++;
        if (if_a.rpt_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure rise: got valid=%b required 1", if_a.rpt_valid);
        end
        for (int i = 0; i < 19; i++) begin
            axis_a = 4'($urandom_range(15));
            tick();
            if (if_a.rpt_valid !== 1'b1 || if_a.rpt_chan !== 4'b0101 || if_a.rpt_cycles !== 16'(TH))
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL backpressure stable: got %0d unstable cycles required 0", bad);
        end
        if_a.rpt_ready = 1'b1;
        tick();
        if_a.rpt_ready = 1'b0;
        n_checks++;
        if (if_a.rpt_valid !== 1'b0 || da_a !== 1'b1 || hang_a !== 16'd28) begin
            n_errors++;
            $display("FAIL backpressure accept: got valid=%b da=%b hang=%0d required 0 1 28",
                     if_a.rpt_valid, da_a, hang_a);
        end
        block_a = 1'b0;
        tick();
        tick();
        $display("backpressure scenario done");
    endtask

    // T4: block drops while the record is pending.
    task automatic test_drop_in_report();
        axis_a  = 4'b1000;
        block_a = 1'b1;
        q_a.push_back('{chan: 4'b1000, cycles: 16'(TH)});
        for (int i = 1; i <= TH; i++) tick();
        block_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_a.rpt_valid !== 1'b1 || da_a !== 1'b0 || hang_a !== 16'd0 || if_a.rpt_chan !== 4'b1000) begin
                n_errors++;
                $display("FAIL drop pending %0d: got valid=%b da=%b hang=%0d chan=%b required 1 0 0 1000",
                         i, if_a.rpt_valid, da_a, hang_a, if_a.rpt_chan);
            end
        end
        if_a.rpt_ready = 1'b1;
        tick();
        if_a.rpt_ready = 1'b0;
        n_checks++;
        if (if_a.rpt_valid !== 1'b0 || da_a !== 1'b0) begin
            n_errors++;
            $display("FAIL drop accept: got valid=%b da=%b required 0 0", if_a.rpt_valid, da_a);
        end
        block_a = 1'b1;
        tick();
        n_checks++;
        if (hang_a !== 16'd1 || da_a !== 1'b0) begin
            n_errors++;
            $display("FAIL drop idle: got hang=%0d da=%b required 1 0", hang_a, da_a);
        end
        block_a = 1'b0;
        tick();
        $display("drop in report scenario done");
    endtask

    // T5: 4-bit counter saturates at 15, one record only.
    task automatic test_saturation();
        int bad = 0;
        axis_b = 4'b0011;
        if_b.rpt_ready = 1'b1;
        block_b = 1'b1;
        q_b.push_back('{chan: 4'b0011, cycles: 16'(TH)});
        for (int i = 1; i <= 40; i++) begin
            int exp_h;
            exp_h = (i > 15) ? 15 : i;
            tick();
            if (hang_b !== 4'(exp_h)) begin
                bad++;
                $display("saturation edge %0d hang=%0d expected %0d", i, hang_b, exp_h);
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL saturation: got %0d wrong counts required 0", bad);
        end
        n_checks++;
        if (rec_b != 1 || da_b !== 1'b1) begin
            n_errors++;
            $display("FAIL saturation records: got %0d da=%b required 1 1", rec_b, da_b);
        end
        block_b = 1'b0;
        tick();
        n_checks++;
        if (hang_b !== 4'd0 || da_b !== 1'b0) begin
            n_errors++;
            $display("FAIL saturation release: got hang=%0d da=%b required 0 0", hang_b, da_b);
        end
        if_b.rpt_ready = 1'b0;
        $display("saturation scenario done");
    endtask

    // T6: reset during REPORT drops the record; next episode reports fresh.
    task automatic test_reset_in_report();
        axis_a  = 4'b0001;
        block_a = 1'b1;
        for (int i = 1; i <= TH; i++) tick();
        reset_n = 1'b0;
        tick();
        n_checks++;
        if (if_a.rpt_valid !== 1'b0 || if_a.rpt_chan !== 4'd0 || if_a.rpt_cycles !== 16'd0 ||
            da_a !== 1'b0 || hang_a !== 16'd0) begin
            n_errors++;
            $display("FAIL reset in report: got valid=%b chan=%b cyc=%0d da=%b hang=%0d required all 0",
                     if_a.rpt_valid, if_a.rpt_chan, if_a.rpt_cycles, da_a, hang_a);
        end
        reset_n = 1'b1;
        q_a.push_back('{chan: 4'b1001, cycles: 16'(TH)});
        for (int i = 1; i <= TH; i++) begin
            axis_a = (i <= TH / 2) ? 4'b0001 : 4'b1000;
            tick();
        end
        n_checks++;
        if (if_a.rpt_valid !== 1'b1 || if_a.rpt_chan !== 4'b1001 || hang_a !== 16'(TH)) begin
            n_errors++;
            $display("FAIL fresh report: got valid=%b chan=%b hang=%0d required 1 1001 %0d",
                     if_a.rpt_valid, if_a.rpt_chan, hang_a, TH);
        end
        if_a.rpt_ready = 1'b1;
        tick();
        if_a.rpt_ready = 1'b0;
        block_a = 1'b0;
        tick();
        tick();
        $display("reset in report scenario done");
    endtask

    task automatic test_scoreboard_drain();
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0 || rec_a != 4 || rec_b != 1) begin
            n_errors++;
            $display("FAIL drain: got pend_a=%0d pend_b=%0d rec_a=%0d rec_b=%0d required 0 0 4 1",
                     q_a.size(), q_b.size(), rec_a, rec_b);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_short_block();
        test_backpressure();
        test_drop_in_report();
        test_saturation();
        test_reset_in_report();
        test_scoreboard_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_decoder_hls_deadlock_reporter
